// File: rtl/product_acc_if.sv
// product_acc_if: handshake bundle between the 4x4 multiplier and the
// product accumulator.
//   prod_valid/prod_ready/product/prod_last : product stream into the accumulator
//   res_valid/res_ready/res_data/res_ovf    : group-sum result stream out of it
// master = upstream/downstream environment, slave = the accumulator.
interface product_acc_if #(
  parameter int unsigned ACC_W = 12
);
  logic             prod_valid;
  logic             prod_ready;
  logic [7:0]       product;
  logic             prod_last;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_ovf;

  modport master (
    output prod_valid, product, prod_last, res_ready,
    input  prod_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  prod_valid, product, prod_last, res_ready,
    output prod_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of up to LEN unsigned 8-bit products
// (one per cycle) and presents each group sum with an overflow flag.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - product_acc_if.slave (product stream in, result stream out)
// Build option: define PRODUCT_ACC_SATURATE_EN to clamp the accumulator at
// 2^ACC_W-1 on overflow; otherwise the accumulator wraps modulo 2^ACC_W.
// Overflow is flagged on res_ovf in both builds.
module product_accumulator #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  product_acc_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam int unsigned SUM_W = ACC_W + 1;
`ifdef PRODUCT_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
`endif

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_prod_ready, w_prod_ready_nxt;
  logic             r_res_valid, w_res_valid_nxt;
  logic [ACC_W-1:0] r_res_data, w_res_data_nxt;
  logic             r_res_ovf, w_res_ovf_nxt;

  logic             w_accept;
  logic             w_end;
  logic [ACC_W-1:0] w_base;
  logic [SUM_W-1:0] w_sum;
  logic             w_step_ovf;
  logic [ACC_W-1:0] w_acc_new;

  // Datapath: one extra sum bit exposes the carry out of the accumulator.
  always_comb begin
    w_accept   = bus.prod_valid && (r_state == ST_ACC);
    w_base     = (r_cnt == '0) ? '0 : r_acc;
    w_sum      = SUM_W'(w_base) + SUM_W'(bus.product);
    w_step_ovf = w_sum[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
    // Once clamped, any later add carries out again, so the clamp holds.
    w_acc_new  = w_step_ovf ? ACC_MAX : w_sum[ACC_W-1:0];
`else
    w_acc_new  = w_sum[ACC_W-1:0];
`endif
    // A last flag on the LEN-th product is a single end event.
    w_end      = w_accept && (bus.prod_last || (r_cnt == CNT_W'(LEN - 1)));
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_res_valid_nxt = r_res_valid;
    w_res_data_nxt  = r_res_data;
    w_res_ovf_nxt   = r_res_ovf;

    case (r_state)
      ST_ACC: begin
        if (w_accept) begin
          w_acc_nxt = w_acc_new;
          w_ovf_nxt = r_ovf | w_step_ovf;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_end) begin
            w_res_data_nxt  = w_acc_new;
            w_res_ovf_nxt   = r_ovf | w_step_ovf;
            w_res_valid_nxt = 1'b1;
            w_cnt_nxt       = '0;
            w_ovf_nxt       = 1'b0;
            w_state_nxt     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = ST_ACC;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase

    // prod_ready is registered from the next state, so it never depends
    // combinationally on res_ready.
    w_prod_ready_nxt = (w_state_nxt == ST_ACC);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ACC;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_prod_ready <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_ovf    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ovf        <= w_ovf_nxt;
      r_prod_ready <= w_prod_ready_nxt;
      r_res_valid  <= w_res_valid_nxt;
      r_res_data   <= w_res_data_nxt;
      r_res_ovf    <= w_res_ovf_nxt;
    end
  end

  assign bus.prod_ready = r_prod_ready;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_ovf    = r_res_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: drives two accumulators (ACC_W=12 and ACC_W=9,
// both LEN=4) from one stimulus stream and checks them every cycle against
// a group-level reference model, plus literal expectations for known groups.
module tb_product_accumulator;

  localparam int unsigned LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       v;
  logic [7:0] p;
  logic       l;
  logic       rr;
  bit         cmp_en = 1'b0;

  always #5 clk = ~clk;

  product_acc_if #(.ACC_W(12)) if12 ();
  product_acc_if #(.ACC_W(9))  if9 ();

  assign if12.prod_valid = v;
  assign if12.product    = p;
  assign if12.prod_last  = l;
  assign if12.res_ready  = rr;
  assign if9.prod_valid  = v;
  assign if9.product     = p;
  assign if9.prod_last   = l;
  assign if9.res_ready   = rr;

  product_accumulator #(.LEN(LEN), .ACC_W(12)) dut12 (.clk(clk), .rst(rst), .bus(if12));
  product_accumulator #(.LEN(LEN), .ACC_W(9))  dut9  (.clk(clk), .rst(rst), .bus(if9));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Group result from the exact (unbounded) sum of the group's products.
  function automatic int group_data(input int s, input int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef PRODUCT_ACC_SATURATE_EN
    return (s > mx) ? mx : s;
`else
    return s % (1 << w);
`endif
  endfunction

  function automatic int group_ovf(input int s, input int w);
    return (s > (1 << w) - 1) ? 1 : 0;
  endfunction

  // Reference model: a group is a list of accepted products; after it ends
  // the block waits for res_ready before accepting again.
  bit m_done;
  bit m_vld;
  int m_d12, m_o12, m_d9, m_o9;
  int q[$];

  always @(posedge clk) begin
    int s;
    if (rst) begin
      m_done = 1'b0; m_vld = 1'b0;
      m_d12 = 0; m_o12 = 0; m_d9 = 0; m_o9 = 0;
      q.delete();
    end else if (m_done) begin
      if (rr) begin
        m_done = 1'b0;
        m_vld  = 1'b0;
      end
    end else if (v) begin
      q.push_back(int'(p));
      if (l || q.size() == LEN) begin
        s = 0;
        foreach (q[i]) s += q[i];
        m_d12 = group_data(s, 12); m_o12 = group_ovf(s, 12);
        m_d9  = group_data(s, 9);  m_o9  = group_ovf(s, 9);
        m_done = 1'b1;
        m_vld  = 1'b1;
        q.delete();
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("prod_ready12", 32'(if12.prod_ready), 32'(!m_done));
      chk("prod_ready9",  32'(if9.prod_ready),  32'(!m_done));
      chk("res_valid12",  32'(if12.res_valid),  32'(m_vld));
      chk("res_valid9",   32'(if9.res_valid),   32'(m_vld));
      chk("res_data12",   32'(if12.res_data),   32'(m_d12));
      chk("res_ovf12",    32'(if12.res_ovf),    32'(m_o12));
      chk("res_data9",    32'(if9.res_data),    32'(m_d9));
      chk("res_ovf9",     32'(if9.res_ovf),     32'(m_o9));
    end
  end

  task automatic step(input logic iv, input logic [7:0] ip, input logic il, input logic irr);
    v = iv; p = ip; l = il; rr = irr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(if12.prod_ready), 32'd1);
    chk({tag, "_valid"}, 32'(if12.res_valid),  32'd0);
    chk({tag, "_data"},  32'(if12.res_data),   32'd0);
    chk({tag, "_ovf"},   32'(if9.res_ovf),     32'd0);
  endtask

  initial begin
    rst = 1'b1; v = 1'b0; p = '0; l = 1'b0; rr = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk_reset_outputs("reset");
    cmp_en = 1'b1;
    rst = 1'b0;

    // Four 15x15 products.
    repeat (4) step(1, 225, 0, 0);
    chk("t1_valid", 32'(if12.res_valid), 32'd1);
    chk("t1_data",  32'(if12.res_data),  32'd900);
    chk("t1_ovf",   32'(if12.res_ovf),   32'd0);
    chk("t1_ready", 32'(if12.prod_ready), 32'd0);
`ifdef PRODUCT_ACC_SATURATE_EN
    chk("t1_data9", 32'(if9.res_data), 32'd511);
`else
    chk("t1_data9", 32'(if9.res_data), 32'd388);
`endif
    chk("t1_ovf9", 32'(if9.res_ovf), 32'd1);
    step(0, 0, 0, 0);
    chk("t1_hold_ready", 32'(if12.prod_ready), 32'd0);
    step(0, 0, 0, 1);
    chk("t1_release_valid", 32'(if12.res_valid), 32'd0);
    chk("t1_release_ready", 32'(if12.prod_ready), 32'd1);
    chk("t1_release_data",  32'(if12.res_data),   32'd900);

    // Early end on prod_last, then a fresh group.
    step(1, 6, 0, 0);
    step(1, 9, 1, 0);
    chk("t2_valid", 32'(if12.res_valid), 32'd1);
    chk("t2_data",  32'(if12.res_data),  32'd15);
    step(0, 0, 0, 1);
    repeat (4) step(1, 1, 0, 0);
    chk("t2_next_data", 32'(if12.res_data), 32'd4);
    step(0, 0, 0, 1);

    // Overflow in the narrow accumulator.
    step(1, 225, 0, 0);
    step(1, 225, 0, 0);
    step(1, 225, 1, 0);
`ifdef PRODUCT_ACC_SATURATE_EN
    chk("t3_data9", 32'(if9.res_data), 32'd511);
`else
    chk("t3_data9", 32'(if9.res_data), 32'd163);
`endif
    chk("t3_ovf9",  32'(if9.res_ovf),  32'd1);
    chk("t3_data12", 32'(if12.res_data), 32'd675);
    step(0, 0, 0, 1);
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
    chk("t3_next_data9", 32'(if9.res_data), 32'd10);
    chk("t3_next_ovf9",  32'(if9.res_ovf),  32'd0);

    // Backpressure: result held, products offered but not taken.
    repeat (5) step(1, 7, 0, 0);
    chk("t4_held_data",  32'(if12.res_data),   32'd10);
    chk("t4_held_ready", 32'(if12.prod_ready), 32'd0);
    step(1, 7, 0, 1);
    chk("t4_release_valid", 32'(if12.res_valid), 32'd0);
    repeat (4) step(1, 7, 0, 0);
    chk("t4_data",  32'(if12.res_data),  32'd28);
    chk("t4_valid", 32'(if12.res_valid), 32'd1);
    step(0, 0, 0, 1);

    // Stalled upstream.
    step(1, 2, 0, 0); step(0, 9, 0, 0); step(0, 9, 0, 0);
    step(1, 3, 0, 0); step(1, 4, 0, 0); step(0, 9, 0, 0);
    chk("t5_no_early_valid", 32'(if12.res_valid), 32'd0);
    step(1, 5, 0, 0);
    chk("t5_data", 32'(if12.res_data), 32'd14);
    step(0, 0, 0, 1);

    // prod_last coinciding with the LEN-th product is one end event.
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("t6_data", 32'(if12.res_data), 32'd4);
    step(0, 0, 0, 1);
    step(1, 5, 1, 0);
    chk("t6_single_data", 32'(if12.res_data), 32'd5);
    step(0, 0, 0, 1);

    // Reset mid-group discards the partial sum.
    step(1, 100, 0, 0);
    step(1, 100, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    chk_reset_outputs("t7_reset");
    rst = 1'b0;
    repeat (4) step(1, 1, 0, 0);
    chk("t7_data", 32'(if12.res_data), 32'd4);
    step(0, 0, 0, 1);

    // Random traffic; products biased high to exercise narrow overflow.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rp;
      rp  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                        : 8'($urandom_range(180, 255));
      rst = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 3) != 0), rp, ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
